// File: rtl/spi_reg_writer.sv
// spi_reg_writer: SPI mode-0 receiver that turns host frames into single-cycle
// register writes on the voice engine's addr/data/valid bus.
// Frame (MSB first): cmd[2:0], addr[4:0], data[DATA_W-1:0] [, parity].
// Optional feature macro: SPI_REG_WRITER_PARITY_EN appends one even-parity bit
// covering every preceding bit of the frame.
module spi_reg_writer #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 16
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              spi_sclk_in,
    input  logic              spi_cs_n_in,
    input  logic              spi_mosi_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid_out,
    output logic              busy_out,
    output logic              frame_err_out
);

`ifdef SPI_REG_WRITER_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int FRAME_LEN = 8 + DATA_W + PAR_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_LEN - 1);
    localparam logic [2:0]       CMD_WRITE = 3'b100;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Even-parity helper: returns 1 when the vector holds an even number of ones.
    function automatic logic f_even_parity_ok(input logic [FRAME_LEN-1:0] vec);
        return ~(^vec);
    endfunction

    // Synchroniser chains plus one delayed copy for edge detection.
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_n_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_n_d;

    // Frame state.
    state_t                 r_state;
    state_t                 w_state_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_next;
    logic [FRAME_LEN-2:0]   r_shift;
    logic [FRAME_LEN-2:0]   w_shift_next;

    // Registered output bus and its next values.
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_data;
    logic                   r_valid;
    logic                   r_busy;
    logic                   r_err;
    logic [ADDR_W-1:0]      w_addr_next;
    logic [DATA_W-1:0]      w_data_next;
    logic                   w_valid_next;
    logic                   w_err_next;

    // Decoded view of the pins and of the frame being completed.
    logic                   w_sclk_s;
    logic                   w_cs_n_s;
    logic                   w_mosi_s;
    logic                   w_sclk_rise;
    logic                   w_cs_rise;
    logic                   w_cs_fall;
    logic [FRAME_LEN-1:0]   w_frame;
    logic [2:0]             w_cmd;
    logic [ADDR_W-1:0]      w_addr_f;
    logic [DATA_W-1:0]      w_data_f;
    logic                   w_par_ok;

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_n_s    = r_cs_n_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_cs_rise   = w_cs_n_s & ~r_cs_n_d;
    assign w_cs_fall   = ~w_cs_n_s & r_cs_n_d;

    // mosi travels through the same number of stages as sclk, so the bit
    // seen alongside a detected rise is the one the host launched for it.
    assign w_frame  = {r_shift, w_mosi_s};
    assign w_cmd    = w_frame[FRAME_LEN-1 -: 3];
    assign w_addr_f = w_frame[FRAME_LEN-9+ADDR_W -: ADDR_W];
    assign w_data_f = w_frame[PAR_W +: DATA_W];

`ifdef SPI_REG_WRITER_PARITY_EN
    assign w_par_ok = f_even_parity_ok(w_frame);
`else
    assign w_par_ok = 1'b1;
`endif

    // Bring the asynchronous SPI pins into the clk_in domain and keep one delayed copy.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_sclk_sync <= {SYNC_STAGES{1'b0}};
            r_cs_n_sync <= {SYNC_STAGES{1'b1}};
            r_mosi_sync <= {SYNC_STAGES{1'b0}};
            r_sclk_d    <= 1'b0;
            r_cs_n_d    <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk_in};
            r_cs_n_sync <= {r_cs_n_sync[SYNC_STAGES-2:0], spi_cs_n_in};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi_in};
            r_sclk_d    <= w_sclk_s;
            r_cs_n_d    <= w_cs_n_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, bit counting, frame decode and strobe generation.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_shift_next = r_shift;
        w_addr_next  = r_addr;
        w_data_next  = r_data;
        w_valid_next = 1'b0;
        w_err_next   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_next = CNT_ZERO;
                if (w_cs_fall) begin
                    w_state_next = ST_SHIFT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // A rise arriving together with cs_n going high still counts:
                // the host launched it while select was active.
                if (w_sclk_rise) begin
                    w_shift_next = w_frame[FRAME_LEN-2:0];
                    if (r_cnt == CNT_LAST) begin
                        w_cnt_next = CNT_ZERO;
                        if ((w_cmd == CMD_WRITE) && w_par_ok) begin
                            w_valid_next = 1'b1;
                            w_addr_next  = w_addr_f;
                            w_data_next  = w_data_f;
                        end else begin
                            w_err_next = 1'b1;
                        end
                    end else begin
                        w_cnt_next = r_cnt + CNT_ONE;
                    end
                end else begin
                    w_cnt_next = r_cnt;
                end
                // Deselect: a partially received frame is reported as dropped.
                if (w_cs_rise) begin
                    w_state_next = ST_IDLE;
                    if (w_cnt_next != CNT_ZERO) begin
                        w_err_next = 1'b1;
                    end else begin
                        w_err_next = w_err_next;
                    end
                    w_cnt_next = CNT_ZERO;
                end else begin
                    w_state_next = ST_SHIFT;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = CNT_ZERO;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_cnt   <= CNT_ZERO;
            r_shift <= {(FRAME_LEN-1){1'b0}};
            r_addr  <= {ADDR_W{1'b0}};
            r_data  <= {DATA_W{1'b0}};
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_shift <= w_shift_next;
            r_addr  <= w_addr_next;
            r_data  <= w_data_next;
            r_valid <= w_valid_next;
            r_busy  <= (w_cnt_next != CNT_ZERO);
            r_err   <= w_err_next;
        end
    end

    assign addr_out       = r_addr;
    assign data_out       = r_data;
    assign data_valid_out = r_valid;
    assign busy_out       = r_busy;
    assign frame_err_out  = r_err;

endmodule

// File: tb/tb_spi_reg_writer.sv
// Bench for spi_reg_writer: table of single frames plus hand-written
// burst, abort, simultaneous-edge and reset sequences. Expected writes are
// queued when a frame is sent and popped when the strobe appears.
module tb_spi_reg_writer;

    localparam int HALF = 40;   // SPI half period: 4 clk_in cycles
`ifdef SPI_REG_WRITER_PARITY_EN
    localparam int FL = 25;
`else
    localparam int FL = 24;
`endif

    logic        clk = 1'b0;
    logic        reset_in;
    logic        spi_sclk_in;
    logic        spi_cs_n_in;
    logic        spi_mosi_in;
    logic [4:0]  addr_out;
    logic [15:0] data_out;
    logic        data_valid_out;
    logic        busy_out;
    logic        frame_err_out;

    always #5 clk = ~clk;

    spi_reg_writer dut (
        .clk_in         (clk),
        .reset_in       (reset_in),
        .spi_sclk_in    (spi_sclk_in),
        .spi_cs_n_in    (spi_cs_n_in),
        .spi_mosi_in    (spi_mosi_in),
        .addr_out       (addr_out),
        .data_out       (data_out),
        .data_valid_out (data_valid_out),
        .busy_out       (busy_out),
        .frame_err_out  (frame_err_out)
    );

    typedef struct {
        logic [4:0]  a;
        logic [15:0] d;
    } exp_t;

    typedef struct {
        logic [7:0]  h;
        logic [15:0] d;
    } vec_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;
    int          err_pend = 0;
    logic [4:0]  last_a   = 5'd0;
    logic [15:0] last_d   = 16'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Output monitor: pops the scoreboard on each strobe and accounts for error pulses.
    always @(negedge clk) begin
        if (data_valid_out && frame_err_out) begin
            chk("strobe_err_same_cycle", 32'(frame_err_out), 32'd0);
        end
        if (data_valid_out) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_strobe", 32'(data_valid_out), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("strobe_addr", 32'(addr_out), 32'(mon_e.a));
                chk("strobe_data", 32'(data_out), 32'(mon_e.d));
                last_a = mon_e.a;
                last_d = mon_e.d;
            end
        end
        if (frame_err_out) begin
            if (err_pend == 0) begin
                chk("unexpected_frame_err", 32'(frame_err_out), 32'd0);
            end else begin
                err_pend--;
            end
        end
    end

    function automatic logic [31:0] mk(input logic [7:0] h, input logic [15:0] d);
`ifdef SPI_REG_WRITER_PARITY_EN
        return {7'd0, h, d, ^{h, d}};
`else
        return {8'd0, h, d};
`endif
    endfunction

    task automatic expect_frame(input logic [7:0] h, input logic [15:0] d);
        exp_t e;
        if (h[7:5] == 3'b100) begin
            e.a = h[4:0];
            e.d = d;
            sb_q.push_back(e);
        end else begin
            err_pend++;
        end
    endtask

    task automatic spi_bit(input logic b);
        spi_mosi_in = b;
        #HALF;
        spi_sclk_in = 1'b1;
        #HALF;
        spi_sclk_in = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            spi_bit(f[FL-1-i]);
        end
    endtask

    task automatic cs_low();
        spi_cs_n_in = 1'b0;
        #HALF;
    endtask

    task automatic cs_high();
        #HALF;
        spi_cs_n_in = 1'b1;
        #(HALF * 2);
    endtask

    task automatic drain(input string name);
        repeat (20) @(negedge clk);
        chk({name, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
        chk({name, "_err_done"}, 32'(err_pend), 32'd0);
        chk({name, "_busy"}, 32'(busy_out), 32'd0);
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = '{8'h80, 16'h1234};
        tbl[1] = '{8'h21, 16'hFFFF};
        tbl[2] = '{8'h9F, 16'hA5A5};
        tbl[3] = '{8'hE3, 16'h0F0F};
        tbl[4] = '{8'h00, 16'h0000};
        tbl[5] = '{8'h81, 16'h0000};
        tbl[6] = '{8'h95, 16'hFFFF};

        reset_in    = 1'b1;
        spi_sclk_in = 1'b0;
        spi_cs_n_in = 1'b1;
        spi_mosi_in = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_addr", 32'(addr_out), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_valid", 32'(data_valid_out), 32'd0);
        chk("rst_busy", 32'(busy_out), 32'd0);
        chk("rst_err", 32'(frame_err_out), 32'd0);
        reset_in = 1'b0;
        #(HALF * 2);

        // Single frames, each under its own chip select.
        for (int i = 0; i < 7; i++) begin
            cs_low();
            expect_frame(tbl[i].h, tbl[i].d);
            send_bits(mk(tbl[i].h, tbl[i].d), FL / 2);
            repeat (2) @(negedge clk);
            chk("tbl_busy_mid", 32'(busy_out), 32'd1);
            send_bits(mk(tbl[i].h, tbl[i].d) << (FL / 2), FL - FL / 2);
            cs_high();
            drain("tbl");
            chk("tbl_addr_hold", 32'(addr_out), 32'(last_a));
            chk("tbl_data_hold", 32'(data_out), 32'(last_d));
        end

        // Burst: two frames under one chip select.
        cs_low();
        expect_frame(8'h83, 16'h8000);
        send_bits(mk(8'h83, 16'h8000), FL);
        repeat (2) @(negedge clk);
        chk("burst_busy_between", 32'(busy_out), 32'd0);
        expect_frame(8'h86, 16'h0003);
        send_bits(mk(8'h86, 16'h0003), FL);
        cs_high();
        drain("burst");

        // Abort after 10 bits, then a clean frame.
        cs_low();
        send_bits(mk(8'h85, 16'h5555), 10);
        repeat (2) @(negedge clk);
        chk("abort_busy", 32'(busy_out), 32'd1);
        err_pend++;
        cs_high();
        drain("abort");
        cs_low();
        expect_frame(8'h90, 16'h000F);
        send_bits(mk(8'h90, 16'h000F), FL);
        cs_high();
        drain("after_abort");

        // Last sclk rise and cs_n rise together: frame still completes.
        cs_low();
        expect_frame(8'h8C, 16'hBEEF);
        send_bits(mk(8'h8C, 16'hBEEF), FL - 1);
        spi_mosi_in = mk(8'h8C, 16'hBEEF) & 32'd1;
        #HALF;
        spi_sclk_in = 1'b1;
        spi_cs_n_in = 1'b1;
        #HALF;
        spi_sclk_in = 1'b0;
        // sclk activity with cs_n high must be ignored.
        send_bits(32'hFFFF_FFFF, 6);
        drain("simul");
        chk("simul_addr", 32'(addr_out), 32'h0C);
        chk("simul_data", 32'(data_out), 32'hBEEF);

        // Reset mid-frame discards the partial frame.
        cs_low();
        send_bits(mk(8'h81, 16'hFFFF), 12);
        reset_in    = 1'b1;
        spi_cs_n_in = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_addr", 32'(addr_out), 32'd0);
        chk("midrst_data", 32'(data_out), 32'd0);
        chk("midrst_busy", 32'(busy_out), 32'd0);
        last_a   = 5'd0;
        last_d   = 16'd0;
        reset_in = 1'b0;
        #(HALF * 2);
        cs_low();
        expect_frame(8'h81, 16'h00AA);
        send_bits(mk(8'h81, 16'h00AA), FL);
        cs_high();
        drain("after_rst");
        chk("after_rst_addr", 32'(addr_out), 32'h01);
        chk("after_rst_data", 32'(data_out), 32'h00AA);

`ifdef SPI_REG_WRITER_PARITY_EN
        // Correct parity strobes, flipped parity bit is dropped.
        cs_low();
        expect_frame(8'h80, 16'h0001);
        send_bits(mk(8'h80, 16'h0001), FL);
        err_pend++;
        send_bits(mk(8'h80, 16'h0001) ^ 32'd1, FL);
        cs_high();
        drain("parity");
        chk("parity_data", 32'(data_out), 32'h0001);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
